// File: rtl/mm_pkg.sv
// mm_pkg: state encoding and sizing defaults for the matrix-multiply sequencer
package mm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WB = 2'd2, DONE = 2'd3} state_t;
  localparam int MM_N  = 2;
  localparam int MM_CW = 16;
  function automatic int aw_f(input int n);
    return $clog2(n * n);
  endfunction
  function automatic int iw_f(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/mm_idx_cnt.sv
// mm_idx_cnt: nested k/j/i wrap counter walking the matrix-multiply loop nest
module mm_idx_cnt #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_k,
  input  logic          inc_ij,
  input  logic          clr,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] k,
  output logic          k_last,
  output logic          ij_last
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  assign k_last  = k == LAST;
  assign ij_last = (i == LAST) && (j == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (inc_k) k <= k_last ? '0 : k + 1'b1;
      if (inc_ij) begin
        j <= (j == LAST) ? '0 : j + 1'b1;
        if (j == LAST) i <= (i == LAST) ? '0 : i + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: i/j/k sequencer for a shared-MAC N x N matrix multiplier.
// Define MM_CYC_CNT_EN to build the saturating busy-cycle counter on cyc_cnt.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int N  = MM_N,
  parameter int AW = aw_f(N),
  parameter int CW = MM_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic [AW-1:0] c_addr,
  output logic          c_we,
  output logic [CW-1:0] cyc_cnt
);
  localparam int IW = iw_f(N);
  state_t state;
  logic [IW-1:0] i, j, k;
  logic k_last, ij_last, go, kill;
  assign go   = (state == IDLE) && start;
  assign kill = (state != IDLE) && abort;
  mm_idx_cnt #(.N(N), .IW(IW)) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_k  ((state == RUN) && !stall),
    .inc_ij (state == WB),
    .clr    (go || kill),
    .i      (i),
    .j      (j),
    .k      (k),
    .k_last (k_last),
    .ij_last(ij_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (kill) state <= IDLE;
    else
      case (state)
        IDLE:    state <= start ? RUN : IDLE;
        RUN:     state <= (!stall && k_last) ? WB : RUN;
        WB:      state <= ij_last ? DONE : RUN;
        default: state <= IDLE;
      endcase
  end
  always_comb begin
    busy    = state != IDLE;
    done    = state == DONE;
    mac_en  = (state == RUN) && !stall;
    mac_clr = mac_en && (k == '0);
    c_we    = state == WB;
    a_addr  = AW'(i) * AW'(N) + AW'(k);
    b_addr  = AW'(k) * AW'(N) + AW'(j);
    c_addr  = AW'(i) * AW'(N) + AW'(j);
  end
`ifdef MM_CYC_CNT_EN
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (go) cnt <= '0;
    else if (busy && cnt != '1) cnt <= cnt + 1'b1;
  end
  assign cyc_cnt = cnt;
`else
  assign cyc_cnt = '0;
`endif
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: checks N=2 and N=3 sequencers against a loop-nest schedule model and a MAC/RAM product model
module tb_mm_seq_ctrl;
  typedef struct {
    bit wb;
    int a;
    int b;
    int c;
    bit clr;
  } slot_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, stall = 0, sel = 0;
  logic busy2, done2, mac_en2, mac_clr2, c_we2;
  logic [1:0] a2, b2, c2;
  logic [15:0] cc2;
  logic busy3, done3, mac_en3, mac_clr3, c_we3;
  logic [3:0] a3, b3, c3;
  logic [15:0] cc3;
  logic o_busy, o_done, o_mac_en, o_mac_clr, o_c_we;
  logic [3:0] o_a, o_b, o_c;
  int total = 0, bad = 0;
  int A[16], B[16], C[16];
  always #5 clk = ~clk;
  mm_seq_ctrl #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort), .stall(stall),
    .busy(busy2), .done(done2), .a_addr(a2), .b_addr(b2), .mac_en(mac_en2),
    .mac_clr(mac_clr2), .c_addr(c2), .c_we(c_we2), .cyc_cnt(cc2)
  );
  mm_seq_ctrl #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort), .stall(stall),
    .busy(busy3), .done(done3), .a_addr(a3), .b_addr(b3), .mac_en(mac_en3),
    .mac_clr(mac_clr3), .c_addr(c3), .c_we(c_we3), .cyc_cnt(cc3)
  );
  assign o_busy    = sel ? busy3 : busy2;
  assign o_done    = sel ? done3 : done2;
  assign o_mac_en  = sel ? mac_en3 : mac_en2;
  assign o_mac_clr = sel ? mac_clr3 : mac_clr2;
  assign o_c_we    = sel ? c_we3 : c_we2;
  assign o_a       = sel ? a3 : {2'b00, a2};
  assign o_b       = sel ? b3 : {2'b00, b2};
  assign o_c       = sel ? c3 : {2'b00, c2};

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp))
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // exp_done: >0 fixed done cycle, 0 no done expected, -1 take it from the schedule model
  task automatic run(input int n, input int st_lo, input int st_hi, input int abort_at,
                     input bit rnd, input int extra_start, input int exp_done, input int exp_we);
    slot_t q[$];
    slot_t s;
    int p = 0, idle = 0, mdone = -1, done_cyc = -1, done_cnt = 0, we_cnt = 0, acc = 0;
    bit dead = 0;
    int eb, em, ec, ea, ebb, ew, ewc, ed;
    sel = (n == 3);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        for (int k = 0; k < n; k++) q.push_back('{0, i * n + k, k * n + j, 0, k == 0});
        q.push_back('{1, 0, 0, i * n + j, 0});
      end
    for (int x = 0; x < 16; x++) begin
      A[x] = $urandom_range(0, 15);
      B[x] = $urandom_range(0, 15);
      C[x] = -1;
    end
    @(negedge clk);
    start = 1;
    stall = 0;
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= 400 && idle < 2; cyc++) begin
      stall = rnd ? ($urandom_range(0, 2) == 0) : (cyc >= st_lo && cyc <= st_hi);
      abort = (cyc == abort_at);
      start = (cyc == extra_start);
      @(negedge clk);
      eb = 0; em = 0; ec = 0; ea = -1; ebb = -1; ew = 0; ewc = -1; ed = 0;
      if (!dead) begin
        eb = 1;
        if (p < q.size()) begin
          s = q[p];
          if (!s.wb) begin
            em = int'(!stall);
            ec = int'(s.clr && !stall);
            ea = s.a;
            ebb = s.b;
          end else begin
            ew = 1;
            ewc = s.c;
          end
        end else ed = 1;
      end
      chk("busy", 32'(o_busy), eb);
      chk("mac_en", 32'(o_mac_en), em);
      chk("mac_clr", 32'(o_mac_clr), ec);
      chk("c_we", 32'(o_c_we), ew);
      chk("done", 32'(o_done), ed);
      if (ea >= 0) begin
        chk("a_addr", 32'(o_a), ea);
        chk("b_addr", 32'(o_b), ebb);
      end
      if (ew != 0) chk("c_addr", 32'(o_c), ewc);
      if (o_mac_en) acc = o_mac_clr ? A[o_a] * B[o_b] : acc + A[o_a] * B[o_b];
      if (o_c_we) begin
        C[o_c] = acc;
        we_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dead) idle++;
      else if (abort) dead = 1;
      else if (p < q.size()) begin
        if (q[p].wb || !stall) p++;
      end else begin
        dead = 1;
        mdone = cyc;
      end
      @(posedge clk);
      #1;
    end
    stall = 0;
    abort = 0;
    start = 0;
    chk("run_finished", 32'(idle >= 2), 1);
    chk("c_we_count", 32'(we_cnt), exp_we);
    chk("done_count", 32'(done_cnt), exp_done != 0 ? 1 : 0);
    if (exp_done != 0) chk("done_cycle", 32'(done_cyc), exp_done > 0 ? exp_done : mdone);
    if (exp_we == n * n)
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          int sum = 0;
          for (int k = 0; k < n; k++) sum += A[i * n + k] * B[k * n + j];
          chk("c_value", 32'(C[i * n + j]), sum);
        end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_done", 32'(done2), 0);
    chk("rst_mac_en", 32'(mac_en2), 0);
    chk("rst_addr", 32'({a2, b2, c2}), 0);
    chk("rst_c_we", 32'(c_we2), 0);
    chk("rst_cyc_cnt", 32'(cc2), 0);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    run(2, 0, -1, 0, 0, 0, 13, 4);
    run(2, 2, 4, 0, 0, 0, 16, 4);
    run(2, 0, -1, 5, 0, 0, 0, 1);
    run(2, 0, -1, 0, 0, 4, 13, 4);
`ifdef MM_CYC_CNT_EN
    chk("cyc_cnt", 32'(cc2), 13);
`else
    chk("cyc_cnt", 32'(cc2), 0);
`endif
    run(3, 0, -1, 0, 0, 0, 37, 9);
    run(3, 0, -1, 0, 1, 0, -1, 9);
    run(2, 0, -1, 0, 1, 0, -1, 4);
    sel = 0;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(posedge clk);
    #3;
    chk("mid_run_busy", 32'(busy2), 1);
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy2), 0);
    chk("arst_mac", 32'({mac_en2, mac_clr2, c_we2, done2}), 0);
    chk("arst_addr", 32'({a2, b2, c2}), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 32'(busy2), 0);
    chk("post_rst_done", 32'(done2), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
